// File: rtl/dma_write_scheduler.sv
// Round-robin scheduler sharing one DMA write engine among NUM_CH descriptor channels.
// Grants one channel at a time, launches the engine, and reports a per-job completion status.
module dma_write_scheduler #(
    parameter int CH_W    = 2,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16,
    localparam int NUM_CH = 2 ** CH_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*32-1:0]    req_addr,
    input  logic [NUM_CH*LEN_W-1:0] req_len,
    output logic [NUM_CH-1:0]       req_ready,
    output logic                    eng_trigger,
    output logic [31:0]             eng_dest_addr,
    output logic [LEN_W-1:0]        eng_length,
    input  logic                    eng_done,
    output logic                    cmpl_valid,
    output logic [CH_W-1:0]         cmpl_ch,
    output logic [1:0]              cmpl_status,
    output logic                    busy,
    output logic [CH_W-1:0]         cur_ch
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_BUSY   = 3'd3;
    localparam logic [2:0] S_CMPL   = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ZERO    = 2'b10;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CH_W-1:0]  rr_ptr;
    logic [TO_W-1:0]  timer;
    logic [CH_W-1:0]  pick;
    logic             pick_found;
    logic [31:0]      sel_addr;
    logic [LEN_W-1:0] sel_len;
    logic             timer_expired;

    // First requester after the last completed channel, wrapping modulo NUM_CH.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!pick_found && req_valid[rr_ptr + CH_W'(i)]) begin
                pick       = rr_ptr + CH_W'(i);
                pick_found = 1'b1;
            end
        end
    end

    assign sel_addr      = req_addr[32*cur_ch +: 32];
    assign sel_len       = req_len[LEN_W*cur_ch +: LEN_W];
    assign timer_expired = (timer == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (enable && pick_found) state_nx = S_GRANT;
            end
            S_GRANT: begin
                if (!req_valid[cur_ch])      state_nx = S_IDLE;
                else if (sel_len == '0)      state_nx = S_CMPL;
                else                         state_nx = S_LAUNCH;
            end
            S_LAUNCH: state_nx = S_BUSY;
            S_BUSY: begin
                if (eng_done || timer_expired) state_nx = S_CMPL;
            end
            S_CMPL:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Pulses default low every cycle; each is raised only on the transition that owns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            rr_ptr        <= CH_W'(NUM_CH - 1);
            timer         <= '0;
            req_ready     <= '0;
            eng_trigger   <= 1'b0;
            eng_dest_addr <= '0;
            eng_length    <= '0;
            cmpl_valid    <= 1'b0;
            cmpl_ch       <= '0;
            cmpl_status   <= '0;
            busy          <= 1'b0;
            cur_ch        <= '0;
        end else begin
            state       <= state_nx;
            busy        <= (state_nx != S_IDLE);
            req_ready   <= '0;
            eng_trigger <= 1'b0;
            cmpl_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_nx == S_GRANT) cur_ch <= pick;
                end
                S_GRANT: begin
                    if (req_valid[cur_ch]) begin
                        req_ready     <= {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch;
                        eng_dest_addr <= sel_addr;
                        eng_length    <= sel_len;
                        if (sel_len == '0) begin
                            cmpl_valid  <= 1'b1;
                            cmpl_ch     <= cur_ch;
                            cmpl_status <= ST_ZERO;
                        end
                    end
                end
                S_LAUNCH: begin
                    eng_trigger <= 1'b1;
                    timer       <= '0;
                end
                S_BUSY: begin
                    timer <= timer + 1'b1;
                    // A done arriving on the expiry cycle still counts as success.
                    if (state_nx == S_CMPL) begin
                        cmpl_valid  <= 1'b1;
                        cmpl_ch     <= cur_ch;
                        cmpl_status <= eng_done ? ST_OK : ST_TIMEOUT;
                    end
                end
                S_CMPL: begin
                    rr_ptr <= cur_ch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_scheduler.sv
// Bench for dma_write_scheduler: round-robin job model feeding an expected queue,
// an engine responder, and a monitor that checks grants, launches and completions.
module tb_dma_write_scheduler;

    localparam int CH_W    = 2;
    localparam int NUM_CH  = 4;
    localparam int LEN_W   = 6;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 16;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_TO   = 2'b01;
    localparam logic [1:0] ST_ZERO = 2'b10;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [5:0]  len;
        logic [1:0]  status;
        logic [5:0]  lat;
    } job_t;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH*32-1:0]    req_addr;
    logic [NUM_CH*LEN_W-1:0] req_len;
    logic [NUM_CH-1:0]       req_ready;
    logic                    eng_trigger;
    logic [31:0]             eng_dest_addr;
    logic [LEN_W-1:0]        eng_length;
    logic                    eng_done;
    logic                    cmpl_valid;
    logic [CH_W-1:0]         cmpl_ch;
    logic [1:0]              cmpl_status;
    logic                    busy;
    logic [CH_W-1:0]         cur_ch;

    dma_write_scheduler #(
        .CH_W(CH_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .eng_trigger(eng_trigger),
        .eng_dest_addr(eng_dest_addr), .eng_length(eng_length),
        .eng_done(eng_done), .cmpl_valid(cmpl_valid), .cmpl_ch(cmpl_ch),
        .cmpl_status(cmpl_status), .busy(busy), .cur_ch(cur_ch)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    job_t        exp_q[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          m_ptr    = NUM_CH - 1;
    logic [31:0] d_addr[NUM_CH];
    int          d_len[NUM_CH];
    int          d_lat[NUM_CH];
    int          done_cnt = 0;
    int          job_ch   = 0;
    int          grants_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected outcome of one job from its descriptor and the engine's response delay.
    function automatic job_t make_job(input int c);
        job_t j;
        j.ch   = 2'(c);
        j.addr = d_addr[c];
        j.len  = 6'(d_len[c]);
        j.lat  = 6'(d_lat[c]);
        if (d_len[c] == 0)                              j.status = ST_ZERO;
        else if (d_lat[c] == 0 || d_lat[c] >= TIMEOUT)  j.status = ST_TO;
        else                                            j.status = ST_OK;
        return j;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) eng_done = 1'b1;
        end
        if (req_ready != '0) begin
            req_valid = req_valid & ~req_ready;
            for (int i = 0; i < NUM_CH; i++) if (req_ready[i]) job_ch = i;
            grants_seen++;
        end
        if (eng_trigger) done_cnt = d_lat[job_ch];
    endtask

    task automatic load_desc(input int c);
        req_addr[32*c +: 32]       = d_addr[c];
        req_len[LEN_W*c +: LEN_W]  = LEN_W'(d_len[c]);
    endtask

    // All channels in mask request together while idle: service order is cyclic from m_ptr+1.
    task automatic start_batch(input logic [NUM_CH-1:0] mask);
        int last;
        last = m_ptr;
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (mask[c]) begin
                exp_q.push_back(make_job(c));
                last = c;
            end
        end
        m_ptr = last;
        for (int c = 0; c < NUM_CH; c++) if (mask[c]) load_desc(c);
        req_valid = req_valid | mask;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            tick();
            n++;
        end
        check("drain_pending_jobs", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_trigger(input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!eng_trigger && n < limit);
        check("trigger_seen", 32'(eng_trigger), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_eng_trigger", 32'(eng_trigger), 32'd0);
        check("rst_eng_dest_addr", eng_dest_addr, 32'd0);
        check("rst_eng_length", 32'(eng_length), 32'd0);
        check("rst_cmpl_valid", 32'(cmpl_valid), 32'd0);
        check("rst_cmpl_ch", 32'(cmpl_ch), 32'd0);
        check("rst_cmpl_status", 32'(cmpl_status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   ready_cyc = 0;
    int   trig_cyc = 0;
    logic trig_seen = 1'b0;
    job_t mon_job;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            trig_seen = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check("grant_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("grant_onehot", 32'($countones(req_ready)), 32'd1);
                    check("grant_ch", 32'(req_ready), 32'd1 << exp_q[0].ch);
                end
                ready_cyc = cyc;
                trig_seen = 1'b0;
            end
            if (eng_trigger) begin
                check("trigger_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("trigger_addr", eng_dest_addr, exp_q[0].addr);
                    check("trigger_len", 32'(eng_length), 32'(exp_q[0].len));
                    check("trigger_after_ready", 32'(cyc - ready_cyc), 32'd1);
                end
                trig_seen = 1'b1;
                trig_cyc  = cyc;
            end
            if (cmpl_valid) begin
                check("cmpl_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_job = exp_q.pop_front();
                    check("cmpl_ch", 32'(cmpl_ch), 32'(mon_job.ch));
                    check("cmpl_status", 32'(cmpl_status), 32'(mon_job.status));
                    check("cmpl_busy", 32'(busy), 32'd1);
                    check("cmpl_cur_ch", 32'(cur_ch), 32'(mon_job.ch));
                    check("cmpl_addr_stable", eng_dest_addr, mon_job.addr);
                    check("cmpl_len_stable", 32'(eng_length), 32'(mon_job.len));
                    check("cmpl_triggered", 32'(trig_seen), 32'(mon_job.status != ST_ZERO));
                    if (mon_job.status == ST_OK)
                        check("cmpl_latency_ok", 32'(cyc - trig_cyc), 32'(mon_job.lat) + 32'd1);
                    else if (mon_job.status == ST_TO)
                        check("cmpl_latency_timeout", 32'(cyc - trig_cyc), 32'(TIMEOUT));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int g;
        int r;
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        eng_done  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            d_addr[c] = '0;
            d_len[c]  = 0;
            d_lat[c]  = 0;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        tick();

        // Fairness: all channels held, two full rounds from reset.
        for (int c = 0; c < NUM_CH; c++) begin
            d_addr[c] = 32'h2000_0000 + 32'(c) * 32'h100;
            d_len[c]  = c + 1;
            d_lat[c]  = 3;
        end
        start_batch(4'b1111);
        wait_drain(400);
        start_batch(4'b1111);
        wait_drain(400);

        // Single job on ch1.
        d_addr[1] = 32'h1000_0000; d_len[1] = 4; d_lat[1] = 6;
        start_batch(4'b0010);
        wait_drain(200);

        // Zero-length descriptor on ch2.
        d_addr[2] = 32'h3000_0040; d_len[2] = 0; d_lat[2] = 3;
        start_batch(4'b0100);
        wait_drain(200);

        // Timeout on ch3 with ch0 pending behind it.
        d_addr[3] = 32'h4000_0000; d_len[3] = 9; d_lat[3] = 0;
        d_addr[0] = 32'h4000_1000; d_len[0] = 2; d_lat[0] = 4;
        start_batch(4'b1001);
        wait_drain(400);

        // Done on the very cycle the timer expires.
        d_addr[1] = 32'h5000_0000; d_len[1] = 1; d_lat[1] = TIMEOUT - 1;
        start_batch(4'b0010);
        wait_drain(200);

        // Enable dropped while busy: job finishes, no new grant until re-enabled.
        d_addr[0] = 32'h6000_0000; d_len[0] = 7; d_lat[0] = 8;
        d_addr[1] = 32'h6000_0100; d_len[1] = 3; d_lat[1] = 2;
        start_batch(4'b0001);
        wait_trigger(50);
        enable = 1'b0;
        load_desc(1);
        req_valid[1] = 1'b1;
        exp_q.push_back(make_job(1));
        m_ptr = 1;
        n = 0;
        while (exp_q.size() > 1 && n < 100) begin
            tick();
            n++;
        end
        check("enable_first_job_done", 32'(exp_q.size()), 32'd1);
        g = grants_seen;
        repeat (20) tick();
        check("disabled_no_grant", 32'(grants_seen - g), 32'd0);
        check("disabled_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_drain(200);

        // Request withdrawn while in GRANT.
        d_addr[3] = 32'h7000_0000; d_len[3] = 5; d_lat[3] = 2;
        load_desc(3);
        req_valid = 4'b1000;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 20);
        check("withdraw_granted", 32'(busy), 32'd1);
        check("withdraw_cur_ch", 32'(cur_ch), 32'd3);
        req_valid = '0;
        g = grants_seen;
        repeat (4) tick();
        check("withdraw_no_ready", 32'(grants_seen - g), 32'd0);
        check("withdraw_idle", 32'(busy), 32'd0);
        for (int c = 0; c < NUM_CH; c++) begin
            d_addr[c] = 32'h7100_0000 + 32'(c);
            d_len[c]  = 2;
            d_lat[c]  = 1;
        end
        start_batch(4'b1111);
        wait_drain(400);

        // Randomized batches, including late and stale done pulses.
        for (int b = 0; b < 30; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                d_addr[c] = $urandom;
                d_len[c]  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
                r = int'($urandom_range(0, 9));
                case (r)
                    0:       d_lat[c] = 0;
                    1:       d_lat[c] = TIMEOUT - 1;
                    2:       d_lat[c] = TIMEOUT;
                    3:       d_lat[c] = TIMEOUT + 2;
                    default: d_lat[c] = int'($urandom_range(1, TIMEOUT - 2));
                endcase
            end
            start_batch(4'($urandom_range(1, 15)));
            wait_drain(600);
        end

        // Asynchronous reset in the middle of a busy job.
        d_addr[2] = 32'hCAFE_0000; d_len[2] = 5; d_lat[2] = 0;
        start_batch(4'b0100);
        wait_trigger(50);
        repeat (3) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        done_cnt  = 0;
        eng_done  = 1'b0;
        req_valid = '0;
        m_ptr     = NUM_CH - 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            d_addr[c] = 32'h8000_0000 + 32'(c) * 32'h10;
            d_len[c]  = 3;
            d_lat[c]  = 2;
        end
        start_batch(4'b1111);
        wait_drain(400);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
